gpia_wb_ctrl: RTL and testbench
===============================

# gpia_wb_ctrl

Wishbone B3 classic slave controller for one GPIA port. Holds the output-latch (OUT) and data-direction (DDR) registers, sequences single-cycle-acked bus transfers, and routes reads through a per-bit input mux: DDR=1 bits read back OUT, DDR=0 bits read the pin. Drives port pins and per-bit output enables toward the pad ring.

## Interface
- WIDTH, 16: port width in bits, 1..64.
- clk_i  in  1  system clock; all state changes on rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- adr_i  in  3  register select.
- dat_i  in  WIDTH  write data.
- dat_o  out  WIDTH  read data; zero whenever ack_o=0, so slave outputs can be OR-ed onto a shared bus.
- ack_o  out  1  transfer acknowledge, one-cycle pulse.
- pin_i  in  WIDTH  external pin levels, asynchronous.
- port_o  out  WIDTH  OUT register.
- port_oe_o  out  WIDTH  DDR register; 1 = drive pin.

## Operation
- Register map by adr_i:
  - 0 INP: read = per-bit (DDR ? OUT : pin); write ignored.
  - 1 OUT: read/write.
  - 2 DDR: read/write.
  - 3 OUTSET: write OUT |= dat_i.
  - 4 OUTCLR: write OUT &= ~dat_i.
  - 5 OUTTGL: write OUT ^= dat_i.
  - Reads at 3, 4 and 5 return OUT.
  - 6, 7: reserved; read 0, write ignored, still acked.
- FSM states IDLE and ACK.
  - IDLE -> ACK on an edge where cyc_i & stb_i. At that edge: ack_o<=1; a read loads dat_o; a write commits to the register and dat_o<=0.
  - ACK -> IDLE unconditionally at the next edge. ack_o<=0 and dat_o<=0 at that edge.
- Strobe held across transfers: one dead cycle between acks, so peak rate is one transfer per 2 clocks. cyc_i or stb_i dropping while in ACK has no effect.
- Full-width writes only; no byte selects.
- Reset values: ack_o=0, dat_o=0, OUT=0, DDR=0 (all pins input, port_oe_o=0), FSM=IDLE, synchronizer flops=0.
- reset_i wins over any transfer. A write sampled on the same edge as reset_i=1 is discarded, and no ack is issued. A reset in ACK state forces ack_o=0 at the next edge.

## Timing
- Transfer latency: ack_o high on the first edge after cyc_i&stb_i is sampled; dat_o valid in that same cycle.
- Effect of a write on port_o/port_oe_o: visible in the ack cycle.
- A read in the cycle immediately following a write returns the new value.
- INP read path with sync: a pin change settled before edge k is first visible to a read whose ack edge is k+2.
- INP read path without sync: first visible to a read whose ack edge is k.

## Configuration
- GPIA_INPUT_SYNC_EN defined: pin_i passes through a 2-flop synchronizer (reset 0) before the input mux.
- GPIA_INPUT_SYNC_EN undefined: pin_i feeds the mux directly and is sampled only by the dat_o register.
- Bus timing is identical in both builds; only pin-to-read latency changes.

## Structure
- Shared package gpia_pkg holds:
  - address constants GPIA_A_INP..GPIA_A_OUTTGL;
  - FSM state encoding (IDLE=0, ACK=1).
- Sub-module: the existing GPIA_BIT_IN cell, instantiated WIDTH times with a generate loop.
  - Connections: out_i=OUT[n], inp_i=pin (synced or raw), ddr_i=DDR[n].
  - stb_i = read of adr 0.
  - The OR of its q_o with other read sources forms the next dat_o.

## Test plan
- Reset state: assert reset_i 2 cycles, WIDTH=16 -> port_o=0000, port_oe_o=0000, ack_o=0, dat_o=0000.
- Register round trip: write OUT=A5C3, DDR=FF00, then read both -> ack exactly one cycle after each strobe; reads return A5C3 and FF00.
- Input mux: DDR=FF00, OUT=A5C3, pin_i=1234, read INP after sync latency -> A534.
- Atomic update operations, starting OUT=00F0:
  - OUTSET 000F -> 00FF;
  - OUTCLR 00F0 -> 000F;
  - OUTTGL FFFF -> FFF0.
- Held strobe plus reserved addresses: hold cyc/stb through 3 reads -> ack pattern 1,0,1,0,1. Read adr 6 -> ack with 0000. Write adr 7 -> no register changes.
- Reset mid-transfer: raise reset_i on the edge a write OUT=FFFF is sampled -> no ack, port_o stays 0000. Test both builds (with and without GPIA_INPUT_SYNC_EN) and check the pin-to-read latency of 2 edges vs 0.

Source files
------------

// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA Wishbone port controller: register map and FSM encoding.
package gpia_pkg;

  localparam logic [2:0] GPIA_A_INP    = 3'd0;
  localparam logic [2:0] GPIA_A_OUT    = 3'd1;
  localparam logic [2:0] GPIA_A_DDR    = 3'd2;
  localparam logic [2:0] GPIA_A_OUTSET = 3'd3;
  localparam logic [2:0] GPIA_A_OUTCLR = 3'd4;
  localparam logic [2:0] GPIA_A_OUTTGL = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } gpia_state_t;

endpackage

// File: rtl/gpia_bit_in.sv
// Per-bit input mux cell: driven bits read back the output latch, input bits read the pin.
module gpia_bit_in (
  input  logic out_i,
  input  logic inp_i,
  input  logic ddr_i,
  input  logic stb_i,
  output logic q_o
);

  assign q_o = stb_i & (ddr_i ? out_i : inp_i);

endmodule

// File: rtl/gpia_wb_ctrl.sv
// Wishbone B3 classic slave for one GPIA port (OUT/DDR registers, atomic set/clr/toggle, input mux).
// Build option: define GPIA_INPUT_SYNC_EN to pass pin_i through a 2-flop synchronizer.
module gpia_wb_ctrl
  import gpia_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [2:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] port_o,
  output logic [WIDTH-1:0] port_oe_o
);

  gpia_state_t      state;
  gpia_state_t      state_nxt;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] ddr_q;
  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] inp_rd;
  logic [WIDTH-1:0] rd_data;
  logic             req;
  logic             rd_inp;

  assign req       = cyc_i & stb_i;
  assign rd_inp    = ~we_i & (adr_i == GPIA_A_INP);
  assign port_o    = out_q;
  assign port_oe_o = ddr_q;

`ifdef GPIA_INPUT_SYNC_EN
  logic [WIDTH-1:0] sync_a;
  logic [WIDTH-1:0] sync_b;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= pin_i;
      sync_b <= sync_a;
    end
  end

  assign pin_s = sync_b;
`else
  // Raw pins are sampled only by the dat_o register below.
  assign pin_s = pin_i;
`endif

  for (genvar n = 0; n < WIDTH; n++) begin : g_bit
    gpia_bit_in u_bit (
      .out_i (out_q[n]),
      .inp_i (pin_s[n]),
      .ddr_i (ddr_q[n]),
      .stb_i (rd_inp),
      .q_o   (inp_rd[n])
    );
  end

  // Each source is zero unless selected, so the read word is a plain OR.
  always_comb begin
    rd_data = inp_rd;
    if (!we_i) begin
      case (adr_i)
        GPIA_A_OUT, GPIA_A_OUTSET, GPIA_A_OUTCLR, GPIA_A_OUTTGL:
          rd_data = inp_rd | out_q;
        GPIA_A_DDR:
          rd_data = inp_rd | ddr_q;
        default:
          rd_data = inp_rd;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      ack_o <= 1'b0;
      dat_o <= '0;
      out_q <= '0;
      ddr_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (req) begin
            ack_o <= 1'b1;
            dat_o <= we_i ? '0 : rd_data;
            if (we_i) begin
              case (adr_i)
                GPIA_A_OUT:    out_q <= dat_i;
                GPIA_A_DDR:    ddr_q <= dat_i;
                GPIA_A_OUTSET: out_q <= out_q | dat_i;
                GPIA_A_OUTCLR: out_q <= out_q & ~dat_i;
                GPIA_A_OUTTGL: out_q <= out_q ^ dat_i;
                default:       ;
              endcase
            end
          end
        end
        default: begin
          ack_o <= 1'b0;
          dat_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpia_wb_ctrl.sv
// Scoreboard bench for gpia_wb_ctrl: directed plan items plus randomized traffic vs a register model.
module tb_gpia_wb_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_i = 1'b0;
  logic         cyc_i = 1'b0;
  logic         stb_i = 1'b0;
  logic         we_i = 1'b0;
  logic [2:0]   adr_i = '0;
  logic [W-1:0] dat_i = '0;
  logic [W-1:0] dat_o;
  logic         ack_o;
  logic [W-1:0] pin_i = '0;
  logic [W-1:0] port_o;
  logic [W-1:0] port_oe_o;

  gpia_wb_ctrl #(.WIDTH(W)) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .cyc_i     (cyc_i),
    .stb_i     (stb_i),
    .we_i      (we_i),
    .adr_i     (adr_i),
    .dat_i     (dat_i),
    .dat_o     (dat_o),
    .ack_o     (ack_o),
    .pin_i     (pin_i),
    .port_o    (port_o),
    .port_oe_o (port_oe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dat;
    logic [W-1:0] port;
    logic [W-1:0] oe;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_ddr = '0;

`ifdef GPIA_INPUT_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Register-map semantics, evaluated at the moment a transfer is issued.
  function automatic logic [W-1:0] model_read(input logic [2:0] a, input logic [W-1:0] pin);
    case (a)
      3'd0:                model_read = (m_ddr & m_out) | (~m_ddr & pin);
      3'd1, 3'd3, 3'd4, 3'd5: model_read = m_out;
      3'd2:                model_read = m_ddr;
      default:             model_read = '0;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] a, input logic [W-1:0] d);
    case (a)
      3'd1: m_out = d;
      3'd2: m_ddr = d;
      3'd3: m_out = m_out | d;
      3'd4: m_out = m_out & ~d;
      3'd5: m_out = m_out ^ d;
      default: ;
    endcase
  endtask

  // Monitor: pops one expectation per ack, and checks the bus-OR rule otherwise.
  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset_i) begin
      if (ack_o) begin
        if (ack_prev) begin
          total++; bad++;
          $display("FAIL ack_width: ack_o high two cycles in a row");
        end
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_ack: got ack with nothing expected");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_dat", 64'(dat_o), 64'(e.dat));
          chk("sb_port", 64'(port_o), 64'(e.port));
          chk("sb_oe", 64'(port_oe_o), 64'(e.oe));
        end
      end else if (dat_o !== '0) begin
        total++; bad++;
        $display("FAIL dat_idle: got %h expected 0000 while ack_o=0", dat_o);
      end
    end
    ack_prev = ack_o;
  end

  task automatic xfer(input logic w, input logic [2:0] a, input logic [W-1:0] d);
    exp_t e;
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    if (w) begin
      model_write(a, d);
      e.dat = '0;
    end else begin
      e.dat = model_read(a, pin_i);
    end
    e.port = m_out;
    e.oe   = m_ddr;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("ack_latency", 64'(ack_o), 64'd1);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_port", 64'(port_o), 64'h0);
    chk("rst_oe", 64'(port_oe_o), 64'h0);
    chk("rst_ack", 64'(ack_o), 64'h0);
    chk("rst_dat", 64'(dat_o), 64'h0);
    @(negedge clk);
    reset_i = 1'b0;
    m_out = '0;
    m_ddr = '0;
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] pin_a;
    logic [W-1:0] pin_b;
    exp_t e;
    int pat [5] = '{1, 0, 1, 0, 1};

    do_reset();

    // Register round trip and input mux
    xfer(1'b1, 3'd1, 16'hA5C3);
    xfer(1'b1, 3'd2, 16'hFF00);
    xfer(1'b0, 3'd1, '0);
    xfer(1'b0, 3'd2, '0);
    pin_i = 16'h1234;
    idle(4);
    xfer(1'b0, 3'd0, '0);
    chk("inp_mux_model", 64'(model_read(3'd0, pin_i)), 64'hA534);

    // Atomic operations from OUT=00F0
    xfer(1'b1, 3'd1, 16'h00F0);
    xfer(1'b1, 3'd3, 16'h000F);
    xfer(1'b0, 3'd1, '0);
    chk("outset", 64'(port_o), 64'h00FF);
    xfer(1'b1, 3'd4, 16'h00F0);
    chk("outclr", 64'(port_o), 64'h000F);
    xfer(1'b1, 3'd5, 16'hFFFF);
    chk("outtgl", 64'(port_o), 64'hFFF0);
    xfer(1'b0, 3'd5, '0);

    // Held strobe: three reads of OUT across five edges
    @(negedge clk);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd1;
    for (int i = 0; i < 3; i++) begin
      e.dat = m_out; e.port = m_out; e.oe = m_ddr;
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack%0d", i), 64'(ack_o), 64'(pat[i]));
    end
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;

    // Reserved addresses
    xfer(1'b0, 3'd6, '0);
    xfer(1'b1, 3'd7, 16'hBEEF);
    xfer(1'b0, 3'd7, '0);
    chk("rsv_port", 64'(port_o), 64'hFFF0);
    chk("rsv_oe", 64'(port_oe_o), 64'hFF00);

    // Reset on the same edge as a write of OUT=FFFF
    @(negedge clk);
    reset_i = 1'b1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 3'd1; dat_i = 16'hFFFF;
    @(posedge clk); #1;
    chk("rstwr_ack", 64'(ack_o), 64'h0);
    chk("rstwr_port", 64'(port_o), 64'h0);
    @(negedge clk);
    reset_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    m_out = '0; m_ddr = '0;
    @(posedge clk); #1;
    chk("rstwr_port2", 64'(port_o), 64'h0);
    chk("rstwr_ack2", 64'(ack_o), 64'h0);
    idle(3);

    // Pin-to-read latency: change pins with the strobe, hold for reads acked at k and k+2
    pin_a = 16'h0F0F;
    pin_b = 16'hC3A5;
    pin_i = pin_a;
    idle(4);
    @(negedge clk);
    pin_i = pin_b;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 3'd0;
    e.port = '0; e.oe = '0;
    e.dat = SYNC ? pin_a : pin_b;
    sb.push_back(e);
    e.dat = pin_b;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_second_ack", 64'(ack_o), 64'h1);
    @(negedge clk);
    cyc_i = 1'b0; stb_i = 1'b0;
    idle(2);

    // Randomized traffic against the model; pins change only with settling time
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 2) begin
        pin_i = W'($urandom);
        idle(4);
      end else begin
        xfer(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom));
      end
    end

    idle(3);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
